sram_data_controller: RTL and testbench
=======================================

# sram_data_controller

Responder for the MEM stage's data-memory port: it accepts the 32-bit load/store request the MEM stage issues and services it on an external 16-bit asynchronous SRAM. Each word is split into two half-word accesses with programmable wait states. It drives `ready` low to freeze the pipeline until the access completes. It sits between the MEM stage and the board SRAM pins, replacing the single-cycle data memory.

## Interface
Parameters:
- `N`, 32: data word / address width on the pipeline side
- `SRAM_AW`, 18: SRAM half-word address width
- `BASE_ADDR`, 1024: byte address mapped to SRAM half-word 0
- `WAIT_CYCLES`, 2: extra cycles per half-word access; each phase lasts WAIT_CYCLES+1 cycles

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge
- `rst`, in, 1: reset; asynchronous, active-low (already decided)
- `MEM_W_EN`, in, 1: store request; held by the MEM stage until `ready`
- `MEM_R_EN`, in, 1: load request; held until `ready`
- `ALU_Res`, in, N: byte address
- `Val_Rm`, in, N: store data
- `read_data`, out, N: load result; held between loads
- `ready`, out, 1: low means freeze the pipeline
- `sram_addr`, out, SRAM_AW: SRAM half-word address
- `sram_dq_out`, out, 16: SRAM write data
- `sram_dq_in`, in, 16: SRAM read data
- `sram_dq_oe`, out, 1: enable for the data-bus driver
- `sram_we_n`, out, 1: SRAM write strobe, active-low

## Operation
- FSM states: IDLE, LOW, HIGH, DONE.
- **IDLE**
  - When `MEM_W_EN|MEM_R_EN` is seen, capture op, address and store data, then go to LOW.
  - If both enables are high, the op is a store and the load is ignored.
- **LOW / HIGH**
  - Each state lasts WAIT_CYCLES+1 cycles, timed by a down-counter that is reloaded on entry.
  - After LOW expires, go to HIGH. After HIGH expires, go to DONE.
- **DONE**
  - Lasts one cycle with `ready`=1, then return to IDLE unconditionally.
  - The MEM stage advances on that edge.
- Address mapping:
  - word index w = ((ALU_Res − BASE_ADDR) >> 2), truncated to SRAM_AW−1 bits (wraps modulo SRAM size).
  - ALU_Res[1:0] is ignored.
  - LOW accesses `sram_addr` = {w,0}; HIGH accesses `sram_addr` = {w,1}.
- Store:
  - `sram_dq_out` = captured data [15:0] in LOW and [31:16] in HIGH.
  - `sram_dq_oe`=1 and `sram_we_n`=0 for all cycles of LOW and HIGH.
- Load:
  - `sram_dq_oe`=0 and `sram_we_n`=1.
  - `sram_dq_in` is sampled on the last cycle of each phase.
  - `read_data` = {high, low} is updated on entry to DONE. Stores never change `read_data`.
- `ready` is combinational: `ready` = (state==DONE) | ~(MEM_W_EN|MEM_R_EN).
- Input changes after capture are ignored until the next IDLE.

## Timing
- Reset values: state IDLE, `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, counter 0.
- While in reset, `ready` follows the combinational rule.
- All SRAM outputs are registered.
- Latency: the request is seen in cycle 0; LOW spans cycles 1..W+1; HIGH spans cycles W+2..2W+2; `ready`=1 in cycle 2W+3 (cycle 7 at the default setting).
- Throughput: one access per 2W+4 cycles. The request seen in the cycle after DONE starts a new access.
- Reset mid-access: abort immediately. `sram_we_n` goes to 1 and `sram_dq_oe` goes to 0 asynchronously. No partial update of `read_data`. A partial SRAM write is permitted.

## Configuration
- `SRAM_READ_HOLD_EN` defined:
  - Add a one-entry register holding {valid, word index, data}.
  - A load whose word index matches a valid entry goes IDLE→DONE directly, giving `ready` in cycle 1 with `read_data` = held data and no SRAM cycle.
  - Every completed SRAM load fills the entry.
  - A store to the matching index updates the held data with the store data.
  - Reset clears valid.
- Not defined: no hold register; every load takes the full SRAM path.

## Test plan
All scenarios use the defaults (W=2, BASE_ADDR=1024).
- **Idle:** no enables for 10 cycles -> `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0 throughout.
- **Store:** store 0xDEADBEEF to address 1024 -> `sram_addr`=0 with `sram_dq_out`=0xBEEF in cycles 1-3; `sram_addr`=1 with 0xDEAD in cycles 4-6; `sram_we_n`=0 in cycles 1-6; `ready` low in cycles 0-6 and high in cycle 7.
- **Load:** load from address 1028, with the SRAM model holding 0x1234 at address 2 and 0x5678 at address 3 -> `read_data`=0x56781234 in cycle 7; `read_data` unchanged by a subsequent store.
- **Simultaneous enables:** store 0xCAFEF00D to 1032 with `MEM_R_EN`=1 -> SRAM addresses 4 and 5 are written; `read_data` unchanged.
- **Reset mid-access:** assert `rst`=0 in cycle 5 of a store -> `sram_we_n`=1 immediately; after release the FSM is in IDLE and `read_data`=0.
- **With `SRAM_READ_HOLD_EN`:** load 1028 twice -> first load `ready` in cycle 7, second load `ready` in cycle 1 with the same data; after a store of 0xAAAA5555 to 1028, a load returns 0xAAAA5555 in cycle 1.

Source files
------------

// File: rtl/sram_data_controller.sv
// sram_data_controller
//
// Data-memory responder for the MEM stage. A 32-bit load or store is turned
// into two 16-bit accesses on an external asynchronous SRAM. The low
// half-word goes first, then the high half-word. Each half-word phase lasts
// WAIT_CYCLES+1 cycles. While the access is in flight `ready` is low, which
// freezes the pipeline. `ready` rises for exactly one cycle (DONE), and the
// MEM stage advances on that edge.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   MEM_W_EN     store request, held until ready
//   MEM_R_EN     load request, held until ready (a store wins if both are set)
//   ALU_Res      byte address (bits [1:0] ignored)
//   Val_Rm       store data
//   read_data    load result, held between loads
//   ready        low = freeze the pipeline
//   sram_addr    SRAM half-word address (registered)
//   sram_dq_out  SRAM write data (registered)
//   sram_dq_in   SRAM read data
//   sram_dq_oe   data-bus driver enable (registered)
//   sram_we_n    SRAM write strobe, active-low (registered)
//
// Optional feature (compile-time macro SRAM_READ_HOLD_EN):
//   This adds a one-entry {valid, word index, data} hold register. A load that
//   hits the entry skips the SRAM and finishes in cycle 1. Every completed
//   SRAM load refills the entry. A store to the held index updates the held
//   data.

module sram_data_controller #(
  parameter int          N           = 32,
  parameter int          SRAM_AW     = 18,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_W_EN,
  input  logic               MEM_R_EN,
  input  logic [N-1:0]       ALU_Res,
  input  logic [N-1:0]       Val_Rm,
  output logic [N-1:0]       read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  // Word index width: one SRAM address bit selects the half-word.
  localparam int WIDX_W = SRAM_AW - 1;
  // The counter must hold WAIT_CYCLES. It keeps at least one bit so the
  // width is legal when WAIT_CYCLES is 0.
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               is_store_reg, is_store_next;
  logic [WIDX_W-1:0]  widx_reg, widx_next;
  logic [15:0]        wdata_hi_reg, wdata_hi_next;
  logic [15:0]        low_reg, low_next;
  logic [N-1:0]       read_data_reg, read_data_next;
  logic [SRAM_AW-1:0] sram_addr_reg, sram_addr_next;
  logic [15:0]        dq_out_reg, dq_out_next;
  logic               oe_reg, oe_next;
  logic               we_n_reg, we_n_next;

  logic              req;
  logic [N-1:0]      offset;
  logic [WIDX_W-1:0] req_widx;

  assign req = MEM_W_EN | MEM_R_EN;

  // The subtraction is done at full width. The shifted result is then
  // truncated, so addresses outside the window wrap modulo the SRAM size.
  assign offset   = ALU_Res - N'(BASE_ADDR);
  assign req_widx = WIDX_W'(offset >> 2);

`ifdef SRAM_READ_HOLD_EN
  logic              hold_valid_reg, hold_valid_next;
  logic [WIDX_W-1:0] hold_idx_reg, hold_idx_next;
  logic [N-1:0]      hold_data_reg, hold_data_next;
  logic              hold_hit;
  logic              hold_match;

  assign hold_match = hold_valid_reg & (hold_idx_reg == req_widx);
  // Only a pure load can hit. A store (even with MEM_R_EN set) must reach the SRAM.
  assign hold_hit   = hold_match & ~MEM_W_EN & MEM_R_EN;
`endif

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------- next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = LOW;
`ifdef SRAM_READ_HOLD_EN
          if (hold_hit) state_next = DONE;
`endif
        end
      end
      LOW:     if (cnt_reg == '0) state_next = HIGH;
      HIGH:    if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- output / datapath logic
  // SRAM pins are registered. Each value is computed here for the state being
  // entered, so the pins are already correct in the first cycle of a phase.
  always_comb begin
    cnt_next       = cnt_reg;
    is_store_next  = is_store_reg;
    widx_next      = widx_reg;
    wdata_hi_next  = wdata_hi_reg;
    low_next       = low_reg;
    read_data_next = read_data_reg;
    sram_addr_next = sram_addr_reg;
    dq_out_next    = dq_out_reg;
    oe_next        = oe_reg;
    we_n_next      = we_n_reg;
`ifdef SRAM_READ_HOLD_EN
    hold_valid_next = hold_valid_reg;
    hold_idx_next   = hold_idx_reg;
    hold_data_next  = hold_data_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req) begin
          // Capture everything once. Later input changes are ignored until
          // the FSM is back in IDLE.
          is_store_next  = MEM_W_EN;
          widx_next      = req_widx;
          wdata_hi_next  = Val_Rm[31:16];
          cnt_next       = CNT_RELOAD;
          sram_addr_next = {req_widx, 1'b0};
          dq_out_next    = Val_Rm[15:0];
          oe_next        = MEM_W_EN;
          we_n_next      = ~MEM_W_EN;
`ifdef SRAM_READ_HOLD_EN
          if (hold_hit) read_data_next = hold_data_reg;
          if (MEM_W_EN && hold_match) hold_data_next = Val_Rm;
`endif
        end
      end
      LOW: begin
        if (cnt_reg == '0) begin
          low_next       = sram_dq_in;
          cnt_next       = CNT_RELOAD;
          sram_addr_next = {widx_reg, 1'b1};
          dq_out_next    = wdata_hi_reg;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      HIGH: begin
        if (cnt_reg == '0) begin
          oe_next   = 1'b0;
          we_n_next = 1'b1;
          if (!is_store_reg) begin
            read_data_next = {sram_dq_in, low_reg};
`ifdef SRAM_READ_HOLD_EN
            hold_valid_next = 1'b1;
            hold_idx_next   = widx_reg;
            hold_data_next  = {sram_dq_in, low_reg};
`endif
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath registers
  // The asynchronous reset aborts an access at once. The write strobe and the
  // bus driver are released without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg       <= '0;
      is_store_reg  <= 1'b0;
      widx_reg      <= '0;
      wdata_hi_reg  <= '0;
      low_reg       <= '0;
      read_data_reg <= '0;
      sram_addr_reg <= '0;
      dq_out_reg    <= '0;
      oe_reg        <= 1'b0;
      we_n_reg      <= 1'b1;
    end else begin
      cnt_reg       <= cnt_next;
      is_store_reg  <= is_store_next;
      widx_reg      <= widx_next;
      wdata_hi_reg  <= wdata_hi_next;
      low_reg       <= low_next;
      read_data_reg <= read_data_next;
      sram_addr_reg <= sram_addr_next;
      dq_out_reg    <= dq_out_next;
      oe_reg        <= oe_next;
      we_n_reg      <= we_n_next;
    end
  end

`ifdef SRAM_READ_HOLD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_reg <= 1'b0;
      hold_idx_reg   <= '0;
      hold_data_reg  <= '0;
    end else begin
      hold_valid_reg <= hold_valid_next;
      hold_idx_reg   <= hold_idx_next;
      hold_data_reg  <= hold_data_next;
    end
  end
`endif

  // `ready` is combinational so that an idle pipeline is never stalled.
  assign ready       = (state_reg == DONE) | ~req;
  assign read_data   = read_data_reg;
  assign sram_addr   = sram_addr_reg;
  assign sram_dq_out = dq_out_reg;
  assign sram_dq_oe  = oe_reg;
  assign sram_we_n   = we_n_reg;

endmodule

// File: tb/tb_sram_data_controller.sv
// Testbench for sram_data_controller in its default build (no read hold
// register).
//
// A behavioural model tracks each request by its cycle offset from the
// cycle the request was seen. It derives the expected pins from the
// phase/latency rules. A word-level reference memory gives the expected load
// results. A half-word SRAM model behind the pins serves the DUT.

module tb_sram_data_controller;

  localparam int W      = 2;
  localparam int BASE   = 1024;
  localparam int AW     = 18;
  localparam int DONE_K = 2 * W + 3;

  logic        clk;
  logic        rst;
  logic        MEM_W_EN, MEM_R_EN;
  logic [31:0] ALU_Res, Val_Rm;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  sram_data_controller #(
    .N(32), .SRAM_AW(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst),
    .MEM_W_EN(MEM_W_EN), .MEM_R_EN(MEM_R_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm),
    .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [15:0] sram_mem [int];   // pin-level SRAM contents, keyed by half-word address
  logic [31:0] ref_mem  [int];   // expected word contents, keyed by word index

  // model of the transaction in flight
  int          k;        // 0 = idle, otherwise cycles since the request was seen
  bit          cur_st;
  int          cur_w;
  logic [31:0] cur_d;
  logic [31:0] exp_rd;

  logic [17:0] smp_addr [0:63];
  logic [15:0] smp_dq   [0:63];
  logic        smp_we   [0:63];
  logic        smp_rdy  [0:63];
  logic        last_ready;
  int          op_len;

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'(BASE)) >> 2;
    return int'(off & ((32'd1 << (AW - 1)) - 32'd1));
  endfunction

  function automatic logic [15:0] mem_rd(input int a);
    return sram_mem.exists(a) ? sram_mem[a] : 16'h0000;
  endfunction

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock cycle: SRAM pin model, comparison against the model, model advance.
  task automatic cycle(input int idx);
    bit req;
    bit half;
    @(negedge clk);
    if (!sram_we_n) sram_mem[int'(sram_addr)] = sram_dq_out;
    sram_dq_in = mem_rd(int'(sram_addr));

    req = MEM_W_EN | MEM_R_EN;
    chk($sformatf("ready k=%0d", k), 32'(ready), 32'((k == DONE_K) || !req));
    if (k >= 1 && k <= 2 * W + 2) begin
      half = (k >= W + 2);
      chk($sformatf("sram_addr k=%0d", k), 32'(sram_addr), 32'((cur_w << 1) | int'(half)));
      chk($sformatf("sram_we_n k=%0d", k), 32'(sram_we_n), 32'(!cur_st));
      chk($sformatf("sram_dq_oe k=%0d", k), 32'(sram_dq_oe), 32'(cur_st));
      if (cur_st)
        chk($sformatf("sram_dq_out k=%0d", k), 32'(sram_dq_out),
            half ? 32'(cur_d[31:16]) : 32'(cur_d[15:0]));
    end else begin
      chk($sformatf("sram_we_n k=%0d", k), 32'(sram_we_n), 32'd1);
      chk($sformatf("sram_dq_oe k=%0d", k), 32'(sram_dq_oe), 32'd0);
    end
    chk($sformatf("read_data k=%0d", k), read_data, exp_rd);

    if (idx >= 0 && idx < 64) begin
      smp_addr[idx] = sram_addr;
      smp_dq[idx]   = sram_dq_out;
      smp_we[idx]   = sram_we_n;
      smp_rdy[idx]  = ready;
    end
    last_ready = ready;

    if (k == 0) begin
      if (req) begin
        cur_st = MEM_W_EN;
        cur_w  = widx(ALU_Res);
        cur_d  = Val_Rm;
        k      = 1;
      end
    end else if (k == DONE_K) begin
      k = 0;
    end else begin
      k++;
      if (k == DONE_K) begin
        if (cur_st) ref_mem[cur_w] = cur_d;
        else        exp_rd = ref_rd(cur_w);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(-1);
  endtask

  task automatic do_op(input bit st, input bit ld, input logic [31:0] a, input logic [31:0] d);
    bit done;
    done     = 1'b0;
    MEM_W_EN = st;
    MEM_R_EN = ld;
    ALU_Res  = a;
    Val_Rm   = d;
    op_len   = 0;
    for (int t = 0; t < 64 && !done; t++) begin
      cycle(t);
      op_len = t + 1;
      if (last_ready) done = 1'b1;
    end
    chk("op_completes", 32'(done), 32'd1);
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b0;
  endtask

  initial begin
    bit          st, ld;
    logic [31:0] a;

    rst        = 1'b0;
    MEM_W_EN   = 1'b0;
    MEM_R_EN   = 1'b0;
    ALU_Res    = '0;
    Val_Rm     = '0;
    sram_dq_in = '0;
    k          = 0;
    exp_rd     = '0;
    last_ready = 1'b0;
    sram_mem[2] = 16'h1234;
    sram_mem[3] = 16'h5678;
    ref_mem[1]  = 32'h56781234;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    rst = 1'b1;

    idle(10);

    // store 0xDEADBEEF to 1024
    do_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    chk("st_addr_c1", 32'(smp_addr[1]), 32'h0);
    chk("st_dq_c1", 32'(smp_dq[1]), 32'hBEEF);
    chk("st_addr_c4", 32'(smp_addr[4]), 32'h1);
    chk("st_dq_c4", 32'(smp_dq[4]), 32'hDEAD);
    chk("st_we_c6", 32'(smp_we[6]), 32'h0);
    chk("st_rdy_c6", 32'(smp_rdy[6]), 32'h0);
    chk("st_rdy_c7", 32'(smp_rdy[7]), 32'h1);
    chk("st_len", op_len, 8);

    // load 1028 from preloaded half-words 2/3
    idle(1);
    do_op(1'b0, 1'b1, 32'd1028, 32'h0);
    chk("ld_lit", read_data, 32'h56781234);
    chk("ld_len", op_len, 8);

    // back-to-back store must not disturb read_data
    do_op(1'b1, 1'b0, 32'd1100, 32'h0BADF00D);
    chk("st_keeps_rd", read_data, 32'h56781234);

    // simultaneous enables: store wins
    do_op(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
    chk("both_mem4", 32'(mem_rd(4)), 32'hF00D);
    chk("both_mem5", 32'(mem_rd(5)), 32'hCAFE);
    chk("both_keeps_rd", read_data, 32'h56781234);
    do_op(1'b0, 1'b1, 32'd1035, 32'h0);
    chk("ld_back_lit", read_data, 32'hCAFEF00D);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      st = 1'($urandom_range(0, 1));
      ld = st ? 1'($urandom_range(0, 1)) : 1'b1;
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 63));
      else a = 32'(BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3));
      do_op(st, ld, a, $urandom);
      idle($urandom_range(0, 2));
    end

    // reset in cycle 5 of a store
    MEM_W_EN = 1'b1;
    MEM_R_EN = 1'b0;
    ALU_Res  = 32'd2000;
    Val_Rm   = 32'h13579BDF;
    for (int c = 0; c < 5; c++) cycle(c);
    chk("pre_rst_we_n", 32'(sram_we_n), 32'h0);
    rst = 1'b0;
    #1;
    chk("async_we_n", 32'(sram_we_n), 32'h1);
    chk("async_dq_oe", 32'(sram_dq_oe), 32'h0);
    MEM_W_EN = 1'b0;
    k        = 0;
    exp_rd   = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("in_rst_ready", 32'(ready), 32'h1);
    chk("in_rst_read_data", read_data, 32'h0);
    rst = 1'b1;
    idle(3);
    do_op(1'b1, 1'b0, 32'd1056, 32'h89ABCDEF);
    do_op(1'b0, 1'b1, 32'd1056, 32'h0);
    chk("post_rst_ld", read_data, 32'h89ABCDEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
